// File: rtl/ddc_line_ctrl.sv
// Lock controller for the FMDLL DDC delay line: SAR search over the delay code, then +/-1 tracking with lock detect.
// Latency: one evaluation = SETTLE_CYC cycles from code change to the next registered code/t_code/tb_code/lock/sat update.
// Backpressure: none; the phase detector is treated as quasi-static and sampled once per evaluation.
//
// Ports:
//   clk, rst_n         reference clock, synchronous active-low reset
//   enable             1 = search/track, 0 = return to IDLE (code retained)
//   pd_up, pd_dn       phase-detector decisions (more / less delay)
//   t_code             one-hot turnaround select, bit[code]
//   tb_code            forward enables, bit i set iff i < code
//   code               binary delay code (line delay = code+1 cells)
//   search_done        high from SAR completion until the next IDLE
//   lock               phase locked
//   sat                one-cycle pulse when a track step is blocked at either end of the line
module ddc_line_ctrl #(
    parameter int N_CELLS    = 16,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       pd_up,
    input  logic                       pd_dn,
    output logic [N_CELLS-1:0]         t_code,
    output logic [N_CELLS-1:0]         tb_code,
    output logic [$clog2(N_CELLS)-1:0] code,
    output logic                       search_done,
    output logic                       lock,
    output logic                       sat
);

    localparam int CW  = $clog2(N_CELLS);
    localparam int IW  = $clog2(CW);
    localparam int SW  = $clog2(SETTLE_CYC);
    localparam int LCW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAR,
        ST_TRACK
    } state_t;

    // Direction of the last tracking step; holds do not overwrite it.
    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_t;

    state_t             state_q,   state_d;
    dir_t               dir_q,     dir_d;
    logic [CW-1:0]      code_q,    code_d;
    logic [N_CELLS-1:0] t_code_q,  t_code_d;
    logic [N_CELLS-1:0] tb_code_q, tb_code_d;
    logic [SW-1:0]      settle_q,  settle_d;
    logic [IW-1:0]      idx_q,     idx_d;
    logic [LCW-1:0]     lcnt_q,    lcnt_d;
    logic               done_q,    done_d;
    logic               lock_q,    lock_d;
    logic               sat_q,     sat_d;

    logic up_step;
    logic dn_step;
    logic blocked;
    logic same_dir;

    assign up_step = pd_up & ~pd_dn;
    assign dn_step = pd_dn & ~pd_up;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        code_d   = code_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        lcnt_d   = lcnt_q;
        done_d   = done_q;
        lock_d   = lock_q;
        sat_d    = 1'b0;
        blocked  = 1'b0;
        same_dir = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lock_d = 1'b0;
                done_d = 1'b0;
                if (enable) begin
                    state_d  = ST_SAR;
                    code_d   = CW'(1) << (CW - 1);
                    idx_d    = IW'(CW - 1);
                    settle_d = SW'(SETTLE_CYC - 1);
                end
            end

            ST_SAR, ST_TRACK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    // Sample cycle: the PD has seen the current code for SETTLE_CYC-1 cycles.
                    settle_d = SW'(SETTLE_CYC - 1);
                    if (state_q == ST_SAR) begin
                        code_d[idx_q] = pd_up;
                        if (idx_q != '0) begin
                            code_d[idx_q - IW'(1)] = 1'b1;
                            idx_d = idx_q - IW'(1);
                        end else begin
                            state_d = ST_TRACK;
                            done_d  = 1'b1;
                            lcnt_d  = '0;
                            dir_d   = DIR_NONE;
                        end
                    end else begin
                        if (up_step) begin
                            blocked  = (code_q == CW'(N_CELLS - 1));
                            same_dir = blocked || (dir_q == DIR_UP);
                            dir_d    = DIR_UP;
                            if (!blocked) begin
                                code_d = code_q + CW'(1);
                            end
                        end else if (dn_step) begin
                            blocked  = (code_q == '0);
                            same_dir = blocked || (dir_q == DIR_DN);
                            dir_d    = DIR_DN;
                            if (!blocked) begin
                                code_d = code_q - CW'(1);
                            end
                        end
                        sat_d = blocked;

                        // Monotonic stepping (including pushing against an end stop) means
                        // we are still slewing; reversals and holds mean we straddle the edge.
                        if (same_dir) begin
                            lcnt_d = '0;
                            lock_d = 1'b0;
                        end else if (lcnt_q != LCW'(LOCK_CNT)) begin
                            lcnt_d = lcnt_q + LCW'(1);
                            lock_d = (lcnt_d == LCW'(LOCK_CNT));
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        t_code_d  = N_CELLS'(1) << code_d;
        tb_code_d = t_code_d - N_CELLS'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_NONE;
            code_q    <= '0;
            t_code_q  <= N_CELLS'(1);
            tb_code_q <= '0;
            settle_q  <= '0;
            idx_q     <= IW'(CW - 1);
            lcnt_q    <= '0;
            done_q    <= 1'b0;
            lock_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            code_q    <= code_d;
            t_code_q  <= t_code_d;
            tb_code_q <= tb_code_d;
            settle_q  <= settle_d;
            idx_q     <= idx_d;
            lcnt_q    <= lcnt_d;
            done_q    <= done_d;
            lock_q    <= lock_d;
            sat_q     <= sat_d;
        end
    end

    assign code        = code_q;
    assign t_code      = t_code_q;
    assign tb_code     = tb_code_q;
    assign search_done = done_q;
    assign lock        = lock_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_ddc_line_ctrl.sv
// Bench for ddc_line_ctrl: evaluation-by-evaluation vector table plus hand-written enable/reset sequences.
// Latency: each table record spans SETTLE_CYC clocks; outputs compared on the falling edge after the update edge.
// Backpressure: none; expectations queued at drive time and popped at the evaluation boundary.
module tb_ddc_line_ctrl;

    localparam int N_CELLS    = 16;
    localparam int SETTLE_CYC = 4;
    localparam int LOCK_CNT   = 8;
    localparam int CW         = $clog2(N_CELLS);

    typedef struct {
        logic up;
        logic dn;
        int   code;
        logic done;
        logic lock;
        logic sat;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               pd_up;
    logic               pd_dn;
    logic [N_CELLS-1:0] t_code;
    logic [N_CELLS-1:0] tb_code;
    logic [CW-1:0]      code;
    logic               search_done;
    logic               lock;
    logic               sat;

    int   checks   = 0;
    int   errors   = 0;
    logic mon_en   = 1'b0;
    int   cur_code = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    ddc_line_ctrl #(
        .N_CELLS    (N_CELLS),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .t_code      (t_code),
        .tb_code     (tb_code),
        .code        (code),
        .search_done (search_done),
        .lock        (lock),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-drive invariant on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("t_onehot", 32'($onehot(t_code)), 32'd1);
            chk("t_tb_disjoint", 32'(t_code & tb_code), 32'd0);
        end
    end

    task automatic chk_outputs(input string tag, input int c, input logic d, input logic l, input logic s);
        logic [31:0] t_exp;
        t_exp = 32'd1 << c;
        chk({tag, "_code"}, 32'(code), 32'(c));
        chk({tag, "_t_code"}, 32'(t_code), t_exp);
        chk({tag, "_tb_code"}, 32'(tb_code), t_exp - 32'd1);
        chk({tag, "_done"}, 32'(search_done), 32'(d));
        chk({tag, "_lock"}, 32'(lock), 32'(l));
        chk({tag, "_sat"}, 32'(sat), 32'(s));
    endtask

    // One evaluation: drive PD, queue the expectation, confirm the code holds while settling.
    task automatic run_eval(input vec_t v);
        vec_t e;
        pd_up = v.up;
        pd_dn = v.dn;
        exp_q.push_back(v);
        for (int k = 0; k < SETTLE_CYC; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < SETTLE_CYC - 1) begin
                chk("settle_code", 32'(code), 32'(cur_code));
                chk("settle_sat", 32'(sat), 32'd0);
            end
        end
        e = exp_q.pop_front();
        chk_outputs("eval", e.code, e.done, e.lock, e.sat);
        cur_code = e.code;
    endtask

    function automatic void add(input logic up, input logic dn, input int c,
                                input logic d, input logic l, input logic s);
        vec_t v;
        v.up = up; v.dn = dn; v.code = c; v.done = d; v.lock = l; v.sat = s;
        vecs.push_back(v);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // SAR toward target 11: 8 -> 12 -> 10 -> 11 -> 10, done on the 4th evaluation.
        add(1, 0, 12, 0, 0, 0);
        add(0, 1, 10, 0, 0, 0);
        add(1, 0, 11, 0, 0, 0);
        add(0, 1, 10, 1, 0, 0);
        // Alternating up/dn: lock on the 8th evaluation.
        for (int i = 0; i < 8; i++) begin
            add((i % 2) == 0, (i % 2) != 0, ((i % 2) == 0) ? 11 : 10, 1, i == 7, 0);
        end
        // Reversal keeps lock, second same-direction step drops it.
        add(1, 0, 11, 1, 1, 0);
        add(1, 0, 12, 1, 0, 0);
        // Climb to the top end and push against it.
        add(1, 0, 13, 1, 0, 0);
        add(1, 0, 14, 1, 0, 0);
        add(1, 0, 15, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 15, 1, 0, 1);
        add(0, 0, 15, 1, 0, 0);
        add(1, 1, 15, 1, 0, 0);
        // Walk down to 0 and push against the bottom end.
        for (int c = 14; c >= 0; c--) add(0, 1, c, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 1, 0, 1);
        // Re-lock near the bottom, finishing at code 1 while locked.
        add(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            add((i % 2) != 0, (i % 2) == 0, ((i % 2) == 0) ? 0 : 1, 1, i == 6, 0);
        end
        add(1, 0, 1, 1, 1, 0);

        rst_n  = 1'b0;
        enable = 1'b0;
        pd_up  = 1'b0;
        pd_dn  = 1'b0;
        cycles(3);
        chk_outputs("reset", 0, 0, 0, 0);
        mon_en = 1'b1;

        rst_n = 1'b1;
        cycles(2);
        chk_outputs("idle", 0, 0, 0, 0);

        enable = 1'b1;
        cycles(1);
        chk_outputs("sar_start", 8, 0, 0, 0);
        cur_code = 8;

        foreach (vecs[i]) run_eval(vecs[i]);

        // Disable mid-settle while locked: IDLE, code retained.
        cycles(2);
        enable = 1'b0;
        cycles(1);
        chk_outputs("disable", 1, 0, 0, 0);
        pd_up = 1'b1;
        cycles(6);
        chk_outputs("idle_hold", 1, 0, 0, 0);

        // Re-enable restarts SAR from the MSB.
        enable = 1'b1;
        cycles(1);
        chk_outputs("reenable", 8, 0, 0, 0);
        cur_code = 8;
        begin
            vec_t v;
            v.up = 1; v.dn = 0; v.code = 12; v.done = 0; v.lock = 0; v.sat = 0;
            run_eval(v);
        end

        // Reset mid-SAR and mid-settle, with enable still high.
        cycles(2);
        rst_n = 1'b0;
        cycles(1);
        chk_outputs("rst_mid_sar", 0, 0, 0, 0);
        cycles(2);
        chk_outputs("rst_hold", 0, 0, 0, 0);

        rst_n = 1'b1;
        cycles(1);
        chk_outputs("sar_restart", 8, 0, 0, 0);
        cur_code = 8;
        begin
            vec_t v;
            v.up = 0; v.dn = 1; v.code = 4; v.done = 0; v.lock = 0; v.sat = 0;
            run_eval(v);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
